// File: rtl/alu_imem_add4.sv
// alu_imem_add4: combinational RV32 ALU, pc+4 adder and reset-to-NOP instruction memory
module alu_imem_add4 #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_in1,
  input  logic [31:0] alu_in2,
  input  logic [3:0]  alu_sel,
  output logic [31:0] alu_out,
  input  logic [31:0] pc,
  output logic [31:0] inst,
  output logic [31:0] pc_plus4,
  input  logic        imem_we,
  input  logic [31:0] imem_waddr,
  input  logic [31:0] imem_wdata
);
  localparam int AW = $clog2(IMEM_DEPTH);
  logic [31:0]   mem [IMEM_DEPTH];
  logic [4:0]    sh;
  logic [31:0]   sra;
  logic          r_ok;
  logic          w_ok;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx;
  logic          unused_bits;
  assign sh          = alu_in2[4:0];
  assign sra         = $signed(alu_in1) >>> sh;
  assign pc_plus4    = pc + 32'd4;
  assign r_ok        = (pc >> (AW + 2)) == 32'd0;
  assign w_ok        = (imem_waddr >> (AW + 2)) == 32'd0;
  assign r_idx       = pc[AW+1:2];
  assign w_idx       = imem_waddr[AW+1:2];
  assign unused_bits = ^{pc[1:0], imem_waddr[1:0]};
  // ALU result selected by alu_sel; unused encodings yield zero
  always_comb begin
    alu_out = alu_sel == 4'd0  ? alu_in1 + alu_in2 :
              alu_sel == 4'd1  ? alu_in1 - alu_in2 :
              alu_sel == 4'd2  ? alu_in1 << sh :
              alu_sel == 4'd3  ? {31'd0, $signed(alu_in1) < $signed(alu_in2)} :
              alu_sel == 4'd4  ? {31'd0, alu_in1 < alu_in2} :
              alu_sel == 4'd5  ? alu_in1 ^ alu_in2 :
              alu_sel == 4'd6  ? alu_in1 >> sh :
              alu_sel == 4'd7  ? sra :
              alu_sel == 4'd8  ? alu_in1 | alu_in2 :
              alu_sel == 4'd9  ? alu_in1 & alu_in2 :
              alu_sel == 4'd10 ? alu_in2 : 32'd0;
  end
  // asynchronous fetch; out-of-range addresses and active reset read as NOP
  always_comb begin
    inst = (rst || !r_ok) ? NOP_INST : mem[r_idx];
  end
  // reset fills every word with NOP; in-range writes land on the rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      for (int i = 0; i < IMEM_DEPTH; i++) mem[i] <= NOP_INST;
    else if (imem_we && w_ok)
      mem[w_idx] <= imem_wdata;
  end
endmodule

// File: tb/tb_alu_imem_add4.sv
// tb_alu_imem_add4: scoreboard bench with directed vectors for alu_imem_add4
module tb_alu_imem_add4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alu_in1 = '0;
  logic [31:0] alu_in2 = '0;
  logic [3:0]  alu_sel = '0;
  logic [31:0] alu_out;
  logic [31:0] pc = '0;
  logic [31:0] inst;
  logic [31:0] pc_plus4;
  logic        imem_we = 1'b0;
  logic [31:0] imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  int checks = 0;
  int failures = 0;
  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;
  exp_t q[$];
  event chk_ev;

  alu_imem_add4 dut (
    .clk(clk), .rst(rst),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel), .alu_out(alu_out),
    .pc(pc), .inst(inst), .pc_plus4(pc_plus4),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata)
  );

  always #5 clk = ~clk;

  task automatic push(input string name, input int kind, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = exp;
    #1;
    q.push_back(e);
    -> chk_ev;
    #1;
  endtask

  task automatic chk_alu(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sel, input logic [31:0] exp);
    alu_in1 = a;
    alu_in2 = b;
    alu_sel = sel;
    push(name, 0, exp);
  endtask

  task automatic chk_inst(input string name, input logic [31:0] addr, input logic [31:0] exp);
    pc = addr;
    push(name, 1, exp);
  endtask

  task automatic chk_pc4(input string name, input logic [31:0] addr, input logic [31:0] exp);
    pc = addr;
    push(name, 2, exp);
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    imem_we    = 1'b1;
    imem_waddr = addr;
    imem_wdata = data;
    @(posedge clk);
    #1;
    imem_we = 1'b0;
  endtask

  // monitor: pops each expectation and compares against the live output it names
  initial begin
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e = q.pop_front();
        act = e.kind == 0 ? alu_out : e.kind == 1 ? inst : pc_plus4;
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL %s: got %08h expected %08h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_inst("reset_pc0", 32'h0, NOP);
    chk_inst("reset_last", 32'h3FC, NOP);

    chk_alu("add_wrap_sign", 32'h7FFF_FFFF, 32'h1, 4'd0, 32'h8000_0000);
    chk_alu("add_wrap_carry", 32'hFFFF_FFFF, 32'h2, 4'd0, 32'h0000_0001);
    chk_alu("sub_wrap", 32'h0, 32'h1, 4'd1, 32'hFFFF_FFFF);
    chk_alu("sll_shamt1", 32'h0000_0001, 32'h0000_0021, 4'd2, 32'h0000_0002);
    chk_alu("sra_shamt4", 32'h8000_0000, 32'h0000_0024, 4'd7, 32'hF800_0000);
    chk_alu("srl_shamt4", 32'h8000_0000, 32'h0000_0024, 4'd6, 32'h0800_0000);
    chk_alu("sra_pos", 32'h4000_0000, 32'h0000_0001, 4'd7, 32'h2000_0000);
    chk_alu("slt_neg", 32'h8000_0000, 32'h1, 4'd3, 32'h1);
    chk_alu("sltu_big", 32'h8000_0000, 32'h1, 4'd4, 32'h0);
    chk_alu("sltu_small", 32'h1, 32'h8000_0000, 4'd4, 32'h1);
    chk_alu("xor", 32'hF0F0_1234, 32'h0FF0_FFFF, 4'd5, 32'hFF00_EDCB);
    chk_alu("or", 32'hF000_000F, 32'h0F00_00F0, 4'd8, 32'hFF00_00FF);
    chk_alu("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd9, 32'hF000_F000);
    chk_alu("lui_pass", 32'h1234_5678, 32'hABCD_E000, 4'd10, 32'hABCD_E000);
    chk_alu("sel11_zero", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd11, 32'h0);
    chk_alu("sel12_zero", 32'h8000_0000, 32'h1, 4'd12, 32'h0);
    chk_alu("sel15_zero", 32'hFFFF_FFFF, 32'h1, 4'd15, 32'h0);

    chk_pc4("pc4_basic", 32'h0000_0010, 32'h0000_0014);
    chk_pc4("pc4_wrap", 32'hFFFF_FFFC, 32'h0000_0000);

    @(negedge clk);
    imem_we    = 1'b1;
    imem_waddr = 32'h8;
    imem_wdata = 32'h0050_0093;
    chk_inst("no_write_through", 32'h8, NOP);
    @(posedge clk);
    #1;
    imem_we = 1'b0;
    chk_inst("load_pc8", 32'h8, 32'h0050_0093);
    chk_inst("load_pcB", 32'hB, 32'h0050_0093);
    chk_inst("load_pcC", 32'hC, NOP);
    write_word(32'h400, 32'hDEAD_BEEF);
    chk_inst("oob_read", 32'h400, NOP);
    chk_inst("oob_no_alias", 32'h0, NOP);
    write_word(32'h3FE, 32'hCAFE_F00D);
    chk_inst("last_word", 32'h3FC, 32'hCAFE_F00D);

    write_word(32'h0, 32'h1111_1111);
    chk_inst("midload_written", 32'h0, 32'h1111_1111);
    @(negedge clk);
    #2;
    rst = 1'b1;
    chk_inst("async_rst_pc0", 32'h0, NOP);
    chk_inst("async_rst_pc8", 32'h8, NOP);
    imem_we    = 1'b1;
    imem_waddr = 32'h4;
    imem_wdata = 32'h2222_2222;
    @(posedge clk);
    #1;
    imem_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_inst("rst_write_ignored", 32'h4, NOP);
    chk_inst("rst_cleared_pc0", 32'h0, NOP);
    chk_inst("rst_cleared_last", 32'h3FC, NOP);
    chk_alu("alu_after_rst", 32'h5, 32'h3, 4'd1, 32'h2);

    #5;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
